// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 serial I/O blocks.
//   sio_state_e  : receive FSM state encoding (idle / shifting a frame)
//   SIO_W16_LAST : bit count of the final bit in a 16-bit frame
//   SIO_W8_LAST  : bit count of the final bit in an 8-bit frame
package jtdsp16_pkg;

  typedef enum logic {
    SioIdle  = 1'b0,
    SioShift = 1'b1
  } sio_state_e;

  localparam int unsigned SIO_W16_LAST = 15;
  localparam int unsigned SIO_W8_LAST  = 7;

endpackage

// File: rtl/jtdsp16_sync2.sv
// Two-flop synchronizer with rising-edge detect for an asynchronous input.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears all flops
//   d    - asynchronous input
//   q    - synchronized level (second stage)
//   rise - one-cycle pulse: synchronized level is 1 and was 0 the cycle before
module jtdsp16_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/jtdsp16_sio_rx.sv
// Serial input receiver for the jtdsp16 SIO.
// A frame starts on an ild rising edge; bits on di are shifted MSB-first on
// each ick rising edge. When the last bit arrives the word is copied to
// sdx_dout and ibf is set. Completing a word while ibf is still set sets the
// sticky ovr flag. A CPU read (sdx_rd qualified by cen) clears ibf and ovr.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   cen       - CPU-rate enable, qualifies sdx_rd only
//   di        - serial data (async)
//   ick, ild  - serial bit clock and frame load (async)
//   ilen      - word length: 0 = 16 bits, 1 = 8 bits
//   sdx_rd    - CPU read strobe
//   sdx_dout  - received word (8-bit words zero-extended)
//   ibf, ovr  - buffer full and sticky overrun flags
// Build option: define JTDSP16_SIO_BYTE_EN to honour ilen; otherwise every
// frame is 16 bits and ilen is ignored.
module jtdsp16_sio_rx
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        di,
  input  logic        ick,
  input  logic        ild,
  input  logic        ilen,
  input  logic        sdx_rd,
  output logic [15:0] sdx_dout,
  output logic        ibf,
  output logic        ovr
);

  logic ick_s, ick_rise;
  logic ild_s, ild_rise;

  jtdsp16_sync2 u_sync_ick (
    .clk  (clk),
    .rst  (rst),
    .d    (ick),
    .q    (ick_s),
    .rise (ick_rise)
  );

  jtdsp16_sync2 u_sync_ild (
    .clk  (clk),
    .rst  (rst),
    .d    (ild),
    .q    (ild_s),
    .rise (ild_rise)
  );

  // Plain synchronizer for data; same depth as ick so data lines up with its edge.
  logic di_s1_q, di_s1_d;
  logic di_s2_q, di_s2_d;

  sio_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] dout_q, dout_d;
  logic        ibf_q, ibf_d;
  logic        ovr_q, ovr_d;
  logic        rd;
  logic [3:0]  last_cnt;
  logic [15:0] shifted;
  logic [15:0] word;

`ifdef JTDSP16_SIO_BYTE_EN
  // Word length latched at frame start so mid-frame ilen changes are ignored.
  logic len8_q, len8_d;
  assign last_cnt = len8_q ? 4'(SIO_W8_LAST) : 4'(SIO_W16_LAST);
  assign word     = len8_q ? {8'h00, shifted[7:0]} : shifted;
`else
  logic unused_ilen;
  assign unused_ilen = ilen ^ ick_s ^ ild_s;
  assign last_cnt    = 4'(SIO_W16_LAST);
  assign word        = shifted;
`endif

  assign rd      = sdx_rd & cen;
  assign shifted = {sr_q[14:0], di_s2_q};

  always_comb begin
    di_s1_d = di;
    di_s2_d = di_s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    ibf_d   = ibf_q;
    ovr_d   = ovr_q;
`ifdef JTDSP16_SIO_BYTE_EN
    len8_d  = len8_q;
`endif
    if (rd) begin
      ibf_d = 1'b0;
      ovr_d = 1'b0;
    end
    // ild outranks a same-cycle ick edge, which is dropped.
    if (ild_rise) begin
      state_d = SioShift;
      cnt_d   = 4'd0;
      sr_d    = 16'd0;
`ifdef JTDSP16_SIO_BYTE_EN
      len8_d  = ilen;
`endif
    end else if (state_q == SioShift && ick_rise) begin
      sr_d  = shifted;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == last_cnt) begin
        state_d = SioIdle;
        dout_d  = word;
        ibf_d   = 1'b1;
        // A same-cycle read consumes the old word, so no overrun.
        if (ibf_q && !rd) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      di_s1_q <= 1'b0;
      di_s2_q <= 1'b0;
      state_q <= SioIdle;
      cnt_q   <= 4'd0;
      sr_q    <= 16'd0;
      dout_q  <= 16'd0;
      ibf_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef JTDSP16_SIO_BYTE_EN
      len8_q  <= 1'b0;
`endif
    end else begin
      di_s1_q <= di_s1_d;
      di_s2_q <= di_s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      ibf_q   <= ibf_d;
      ovr_q   <= ovr_d;
`ifdef JTDSP16_SIO_BYTE_EN
      len8_q  <= len8_d;
`endif
    end
  end

  assign sdx_dout = dout_q;
  assign ibf      = ibf_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Self-checking bench for jtdsp16_sio_rx: directed scenarios plus random frames,
// compared against a bit-queue reference model of the receiver.
module tb_jtdsp16_sio_rx;

`ifdef JTDSP16_SIO_BYTE_EN
  localparam bit ByteEn = 1'b1;
`else
  localparam bit ByteEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cen, di, ick, ild, ilen, sdx_rd;
  logic [15:0] sdx_dout;
  logic        ibf, ovr;

  int checks = 0;
  int errors = 0;

  jtdsp16_sio_rx dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .di       (di),
    .ick      (ick),
    .ild      (ild),
    .ilen     (ilen),
    .sdx_rd   (sdx_rd),
    .sdx_dout (sdx_dout),
    .ibf      (ibf),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  // Reference model: collect bits since the last frame start, emit a word
  // once the frame length is reached.
  bit          m_active;
  int          m_len;
  bit          m_bits[$];
  logic [15:0] exp_dout;
  logic        exp_ibf, exp_ovr;

  function automatic void model_reset();
    m_active = 0;
    m_bits.delete();
    exp_dout = 16'h0;
    exp_ibf  = 1'b0;
    exp_ovr  = 1'b0;
  endfunction

  function automatic void model_ild();
    m_active = 1;
    m_bits.delete();
    m_len = (ByteEn && ilen) ? 8 : 16;
  endfunction

  function automatic void model_read();
    exp_ibf = 1'b0;
    exp_ovr = 1'b0;
  endfunction

  function automatic void model_ick(input bit d);
    int unsigned w;
    if (!m_active) return;
    m_bits.push_back(d);
    if (m_bits.size() == m_len) begin
      w = 0;
      foreach (m_bits[i]) w = w * 2 + m_bits[i];
      if (exp_ibf) exp_ovr = 1'b1;
      exp_ibf  = 1'b1;
      exp_dout = 16'(w);
      m_active = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"}, sdx_dout, exp_dout);
    chk({tag, ".ibf"}, {15'd0, ibf}, {15'd0, exp_ibf});
    chk({tag, ".ovr"}, {15'd0, ovr}, {15'd0, exp_ovr});
  endtask

  // mode 0: plain pulse; 1: check 3-cycle capture latency; 2: CPU read lands
  // in the capture cycle.
  task automatic ick_pulse(input bit d, input int mode);
    @(negedge clk);
    di  = d;
    ick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    if (mode == 1) begin
      #1;
      chk("lat_before", {15'd0, ibf}, 16'd0);
    end
    if (mode == 2) begin
      @(negedge clk);
      sdx_rd = 1'b1;
      cen    = 1'b1;
      model_read();
    end
    model_ick(d);
    @(posedge clk);
    #1;
    if (mode == 1) chk("lat_at3", {15'd0, ibf}, 16'd1);
    if (mode == 2) begin
      chk_all("rd_and_done");
      @(negedge clk);
      sdx_rd = 1'b0;
      cen    = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    ick = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic ild_pulse(input bit with_ick);
    @(negedge clk);
    ild = 1'b1;
    if (with_ick) begin
      ick = 1'b1;
      di  = 1'b1;
    end
    model_ild();
    repeat (4) @(posedge clk);
    @(negedge clk);
    ild = 1'b0;
    ick = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input int last_mode);
    for (int i = n - 1; i >= 0; i--) ick_pulse(w[i], (i == 0) ? last_mode : 0);
  endtask

  task automatic cpu_read(input bit en);
    @(negedge clk);
    sdx_rd = 1'b1;
    cen    = en;
    @(posedge clk);
    @(negedge clk);
    sdx_rd = 1'b0;
    cen    = 1'b0;
    if (en) model_read();
    #1;
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; cen = 1'b0; di = 1'b0; ick = 1'b0; ild = 1'b0; ilen = 1'b0; sdx_rd = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 16-bit frame with latency check.
    ild_pulse(0);
    send_bits(16'hA5C3, 16, 1);
    #1; chk_all("w16_a5c3");
    chk("w16_lit", sdx_dout, 16'hA5C3);

    // Overrun.
    cpu_read(1);
    ild_pulse(0); send_bits(16'h1234, 16, 0);
    ild_pulse(0); send_bits(16'h5678, 16, 0);
    #1; chk_all("ovr_set");
    chk("ovr_lit", {15'd0, ovr}, 16'd1);
    cpu_read(1);
    chk_all("ovr_read");
    chk("ovr_read_dout", sdx_dout, 16'h5678);

    // Byte mode (only completes when the byte option is built in).
    ilen = 1'b1;
    ild_pulse(0);
    send_bits(16'h009E, 8, 0);
    #1; chk_all("byte_9e");
    ilen = 1'b0;
    cpu_read(1);

    // Restart mid-frame.
    ild_pulse(0);
    send_bits(16'h0015, 5, 0);
    ild_pulse(0);
    send_bits(16'hFFFF, 16, 0);
    #1; chk_all("restart");

    // Completion coinciding with a CPU read (ibf is already set here).
    w = 16'($urandom);
    ild_pulse(0);
    send_bits(w, 16, 2);
    chk_all("rd_and_done_after");

    // ild and ick edges together: that ick edge must not count as a bit.
    cpu_read(1);
    ild_pulse(1);
    w = 16'($urandom);
    send_bits(w, 15, 0);
    #1; chk_all("ild_ick_15");
    ick_pulse(w[0], 0);
    #1; chk_all("ild_ick_16");

    // Read with cen low is ignored.
    cpu_read(0);
    chk_all("rd_no_cen");

    // ick edges while idle are ignored.
    send_bits(16'h0007, 3, 0);
    #1; chk_all("idle_ick");

    // Reset mid-frame.
    ild_pulse(0);
    send_bits(16'h01AB, 9, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_all("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_bits(16'h0003, 2, 0);
    ild_pulse(0);
    send_bits(16'h00FF, 16, 0);
    #1; chk_all("post_reset");

    // Random frames: random length select, mid-frame ilen flips, random reads.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) cpu_read(1);
      ilen = 1'($urandom_range(0, 1));
      ild_pulse(0);
      w = 16'($urandom);
      for (int i = m_len - 1; i >= 0; i--) begin
        if (i == 4) ilen = ~ilen;
        ick_pulse(w[i], 0);
      end
      #1; chk_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
